// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle MIPS control FSM and its datapath.
// The controller (master) reads the latched opcode/funct fields and drives
// every datapath strobe, mux select and ALU operation code.
interface mips_multicycle_control_if;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       BranchEq;
    logic       PCSrc;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       BranchNeq;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUControl;
    logic [3:0] State_o;
    logic       Illegal_o;

    modport master (
        input  Opcode, Funct,
        output IorD, MemWrite, IRWrite, PCWrite, BranchEq, PCSrc, ALUSrcA,
               RegWrite, MemtoReg, RegDst, BranchNeq, ALUSrcB, ALUControl,
               State_o, Illegal_o
    );

    modport slave (
        output Opcode, Funct,
        input  IorD, MemWrite, IRWrite, PCWrite, BranchEq, PCSrc, ALUSrcA,
               RegWrite, MemtoReg, RegDst, BranchNeq, ALUSrcB, ALUControl,
               State_o, Illegal_o
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Moore-style control FSM for the multicycle MIPS datapath. Sequences
// fetch/decode/execute/memory/writeback and decodes opcode/funct into ALU
// operations. All outputs are combinational from the state register plus the
// instruction fields; reset additionally masks every write enable.
module mips_multicycle_control (
    input  logic                       clk,
    input  logic                       reset,
    mips_multicycle_control_if.master  ctrl
);
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BRANCH   = 4'd8,
        S_IMM_EX   = 4'd9,
        S_IMM_WB   = 4'd10
    } state_t;

    state_t state_q;
    state_t state_d;

    // Instruction class decode; only meaningful from DECODE onward.
    logic       is_rtype, is_lw, is_sw, is_beq, is_bne, is_imm;
    logic       funct_ok;
    logic [3:0] funct_alu;
    logic [3:0] imm_alu;

    // Opcode and funct decode into instruction classes and ALU codes.
    always_comb begin
        is_rtype  = (ctrl.Opcode == OP_RTYPE);
        is_lw     = (ctrl.Opcode == OP_LW);
        is_sw     = (ctrl.Opcode == OP_SW);
        is_beq    = (ctrl.Opcode == OP_BEQ);
        is_bne    = (ctrl.Opcode == OP_BNE);
        is_imm    = (ctrl.Opcode == OP_ADDI) || (ctrl.Opcode == OP_SLTI) ||
                    (ctrl.Opcode == OP_ANDI) || (ctrl.Opcode == OP_ORI);
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (ctrl.Funct)
            6'h20:   funct_alu = ALU_ADD;
            6'h22:   funct_alu = ALU_SUB;
            6'h24:   funct_alu = ALU_AND;
            6'h25:   funct_alu = ALU_OR;
            6'h27:   funct_alu = ALU_NOR;
            6'h2A:   funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
        imm_alu = ALU_ADD;
        case (ctrl.Opcode)
            OP_SLTI: imm_alu = ALU_SLT;
            OP_ANDI: imm_alu = ALU_AND;
            OP_ORI:  imm_alu = ALU_OR;
            default: imm_alu = ALU_ADD;
        endcase
    end

    // State register; reset takes effect on the clock edge only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs; every output defaults to 0 / ALU_ADD.
    always_comb begin
        state_d         = S_FETCH;
        ctrl.IorD       = 1'b0;
        ctrl.MemWrite   = 1'b0;
        ctrl.IRWrite    = 1'b0;
        ctrl.PCWrite    = 1'b0;
        ctrl.BranchEq   = 1'b0;
        ctrl.PCSrc      = 1'b0;
        ctrl.ALUSrcA    = 1'b0;
        ctrl.RegWrite   = 1'b0;
        ctrl.MemtoReg   = 1'b0;
        ctrl.RegDst     = 1'b0;
        ctrl.BranchNeq  = 1'b0;
        ctrl.ALUSrcB    = 2'b00;
        ctrl.ALUControl = ALU_ADD;
        ctrl.Illegal_o  = 1'b0;

        case (state_q)
            S_FETCH: begin
                ctrl.IRWrite = 1'b1;
                ctrl.PCWrite = 1'b1;
                ctrl.ALUSrcB = 2'b01;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed here speculatively.
                ctrl.ALUSrcB = 2'b11;
                if (is_lw || is_sw)              state_d = S_MEMADR;
                else if (is_rtype && funct_ok)   state_d = S_RTYPE_EX;
                else if (is_beq || is_bne)       state_d = S_BRANCH;
                else if (is_imm)                 state_d = S_IMM_EX;
                else begin
                    // Unsupported encodings retire as a nop.
                    ctrl.Illegal_o = 1'b1;
                    state_d        = S_FETCH;
                end
            end
            S_MEMADR: begin
                ctrl.ALUSrcA = 1'b1;
                ctrl.ALUSrcB = 2'b10;
                if (is_lw)      state_d = S_MEMRD;
                else if (is_sw) state_d = S_MEMWR;
                else            state_d = S_FETCH;
            end
            S_MEMRD: begin
                ctrl.IorD = 1'b1;
                state_d   = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.MemtoReg = 1'b1;
                ctrl.RegWrite = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.IorD     = 1'b1;
                ctrl.MemWrite = 1'b1;
                state_d       = S_FETCH;
            end
            S_RTYPE_EX: begin
                ctrl.ALUSrcA    = 1'b1;
                ctrl.ALUControl = funct_alu;
                state_d         = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                ctrl.RegDst   = 1'b1;
                ctrl.RegWrite = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                // The datapath ORs PCWrite with (branch strobe & zero flag).
                ctrl.ALUSrcA    = 1'b1;
                ctrl.ALUControl = ALU_SUB;
                ctrl.PCSrc      = 1'b1;
                ctrl.BranchEq   = is_beq;
                ctrl.BranchNeq  = is_bne;
                state_d         = S_FETCH;
            end
            S_IMM_EX: begin
                ctrl.ALUSrcA    = 1'b1;
                ctrl.ALUSrcB    = 2'b10;
                ctrl.ALUControl = imm_alu;
                state_d         = S_IMM_WB;
            end
            S_IMM_WB: begin
                ctrl.RegWrite = 1'b1;
                state_d       = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset masks every enable immediately so an aborted instruction
        // cannot leave a partial write behind.
        if (reset) begin
            ctrl.MemWrite  = 1'b0;
            ctrl.IRWrite   = 1'b0;
            ctrl.PCWrite   = 1'b0;
            ctrl.RegWrite  = 1'b0;
            ctrl.BranchEq  = 1'b0;
            ctrl.BranchNeq = 1'b0;
            ctrl.Illegal_o = 1'b0;
        end
    end

    assign ctrl.State_o = state_q;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed testbench for mips_multicycle_control: walks each instruction
// class through its state sequence and checks hand-derived control values.
module tb_mips_multicycle_control;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    mips_multicycle_control_if bus ();

    mips_multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled at the negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
        bus.Opcode = op;
        bus.Funct  = fn;
        $display("instr op=%02h funct=%02h", op, fn);
    endtask

    // Write enables packed for compact checks: {MemWrite,IRWrite,PCWrite,RegWrite}.
    function automatic logic [3:0] wen();
        return {bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite};
    endfunction

    initial begin
        reset = 1'b1;
        bus.Opcode = 6'h2B;
        bus.Funct  = 6'h00;
        @(negedge clk);

        // Reset held three cycles: FETCH loaded, every enable masked.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_state", 32'(bus.State_o), 32'd0);
            check("rst_wen", 32'(wen()), 32'h0);
            check("rst_branch", 32'({bus.BranchEq, bus.BranchNeq, bus.Illegal_o}), 32'h0);
        end
        reset = 1'b0;
        #1;
        check("fetch_wen", 32'(wen()), 32'b0110);
        check("fetch_srcb", 32'(bus.ALUSrcB), 32'd1);
        check("fetch_pcsrc", 32'(bus.PCSrc), 32'd0);

        // R-type sub: 0,1,6,7,0
        set_instr(6'h00, 6'h22);
        step();
        check("sub_s1", 32'(bus.State_o), 32'd1);
        check("dec_srcb", 32'(bus.ALUSrcB), 32'd3);
        check("dec_wen", 32'(wen()), 32'h0);
        check("dec_illegal", 32'(bus.Illegal_o), 32'd0);
        step();
        check("sub_s6", 32'(bus.State_o), 32'd6);
        check("sub_alu", 32'(bus.ALUControl), 32'd1);
        check("sub_srca", 32'(bus.ALUSrcA), 32'd1);
        check("sub_srcb", 32'(bus.ALUSrcB), 32'd0);
        check("sub_ex_wen", 32'(wen()), 32'h0);
        step();
        check("sub_s7", 32'(bus.State_o), 32'd7);
        check("sub_wb", 32'({bus.RegDst, bus.RegWrite, bus.MemtoReg}), 32'b110);
        step();
        check("sub_s0", 32'(bus.State_o), 32'd0);

        // lw: 0,1,2,3,4,0
        set_instr(6'h23, 6'h00);
        step();
        check("lw_s1", 32'(bus.State_o), 32'd1);
        step();
        check("lw_s2", 32'(bus.State_o), 32'd2);
        check("lw_adr", 32'({bus.ALUSrcA, bus.ALUSrcB, bus.IorD}), 32'b1100);
        step();
        check("lw_s3", 32'(bus.State_o), 32'd3);
        check("lw_rd", 32'({bus.IorD, bus.RegWrite, bus.MemWrite}), 32'b100);
        step();
        check("lw_s4", 32'(bus.State_o), 32'd4);
        check("lw_wb", 32'({bus.IorD, bus.MemtoReg, bus.RegWrite, bus.RegDst}), 32'b0110);
        step();
        check("lw_s0", 32'(bus.State_o), 32'd0);

        // sw: 0,1,2,5,0 with RegWrite never set and MemWrite for one cycle
        set_instr(6'h2B, 6'h00);
        begin
            int mw_cycles = 0;
            int rw_seen = 0;
            logic [3:0] exp_seq [4] = '{4'd1, 4'd2, 4'd5, 4'd0};
            for (int i = 0; i < 4; i++) begin
                step();
                check($sformatf("sw_state%0d", i), 32'(bus.State_o), 32'(exp_seq[i]));
                mw_cycles += int'(bus.MemWrite);
                rw_seen   += int'(bus.RegWrite);
                if (i == 2) check("sw_wr", 32'({bus.IorD, bus.MemWrite}), 32'b11);
            end
            check("sw_mw_cycles", 32'(mw_cycles), 32'd1);
            check("sw_no_regwrite", 32'(rw_seen), 32'd0);
        end

        // bne: 0,1,8,0
        set_instr(6'h05, 6'h00);
        step();
        step();
        check("bne_s8", 32'(bus.State_o), 32'd8);
        check("bne_strobes", 32'({bus.BranchNeq, bus.BranchEq, bus.PCSrc, bus.PCWrite}), 32'b1010);
        check("bne_alu", 32'(bus.ALUControl), 32'd1);
        check("bne_src", 32'({bus.ALUSrcA, bus.ALUSrcB}), 32'b100);
        step();
        check("bne_s0", 32'(bus.State_o), 32'd0);

        // beq: strobe polarity swapped
        set_instr(6'h04, 6'h00);
        step();
        step();
        check("beq_strobes", 32'({bus.BranchNeq, bus.BranchEq, bus.PCSrc}), 32'b011);
        step();

        // ori: 0,1,9,10,0
        set_instr(6'h0D, 6'h00);
        step();
        step();
        check("ori_s9", 32'(bus.State_o), 32'd9);
        check("ori_alu", 32'(bus.ALUControl), 32'd3);
        check("ori_src", 32'({bus.ALUSrcA, bus.ALUSrcB}), 32'b110);
        step();
        check("ori_s10", 32'(bus.State_o), 32'd10);
        check("ori_wb", 32'({bus.RegWrite, bus.RegDst, bus.MemtoReg}), 32'b100);
        step();

        // slti / andi / addi ALU codes in IMM_EX
        begin
            logic [5:0] ops  [3] = '{6'h0A, 6'h0C, 6'h08};
            logic [3:0] alus [3] = '{4'd4, 4'd2, 4'd0};
            for (int i = 0; i < 3; i++) begin
                set_instr(ops[i], 6'h00);
                step();
                step();
                check($sformatf("imm_alu_%02h", ops[i]), 32'(bus.ALUControl), 32'(alus[i]));
                step();
                step();
            end
        end

        // R-type nor / slt / and / or / add ALU codes in RTYPE_EX
        begin
            logic [5:0] fns  [5] = '{6'h27, 6'h2A, 6'h24, 6'h25, 6'h20};
            logic [3:0] alus [5] = '{4'd5, 4'd4, 4'd2, 4'd3, 4'd0};
            for (int i = 0; i < 5; i++) begin
                set_instr(6'h00, fns[i]);
                step();
                step();
                check($sformatf("r_alu_%02h", fns[i]), 32'(bus.ALUControl), 32'(alus[i]));
                step();
                step();
            end
        end

        // Illegal opcode 0x3F: flagged in DECODE, back to FETCH
        set_instr(6'h3F, 6'h00);
        step();
        check("ill_op_flag", 32'(bus.Illegal_o), 32'd1);
        step();
        check("ill_op_next", 32'(bus.State_o), 32'd0);

        // Illegal funct on R-type
        set_instr(6'h00, 6'h01);
        step();
        check("ill_fn_flag", 32'(bus.Illegal_o), 32'd1);
        step();
        check("ill_fn_next", 32'(bus.State_o), 32'd0);

        // Reset asserted in RTYPE_WB masks RegWrite and aborts to FETCH
        set_instr(6'h00, 6'h20);
        step();
        step();
        step();
        check("abort_in_wb", 32'(bus.State_o), 32'd7);
        reset = 1'b1;
        #1;
        check("abort_regwrite", 32'(bus.RegWrite), 32'd0);
        @(negedge clk);
        check("abort_state", 32'(bus.State_o), 32'd0);
        check("abort_wen", 32'(wen()), 32'h0);
        reset = 1'b0;
        #1;
        check("abort_fetch_wen", 32'(wen()), 32'b0110);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
